mips16_mc_control: RTL and testbench
====================================

# mips16_mc_control

Multi-cycle control sequencer for the 16-bit MIPS datapath. It drives the shared ALU, register file, instruction register and unified memory port through the fetch, decode, execute, memory and writeback phases. It decodes the 3-bit opcode and 4-bit funct fields held in the instruction register. It handles a ready-based memory handshake, traps illegal encodings into a halt state, and counts retired instructions.

## Interface
- RETIRE_W, 16, width of retired-instruction counter
- clk  input  1  system clock, rising-edge
- rst_n  input  1  reset, asynchronous assert, active-low
- opcode  input  3  IR[15:13]; stable except on ir_write
- funct  input  4  IR[3:0]
- mem_ready  input  1  memory completes current access this cycle
- pc_write  output  1  load PC with PC+1
- ir_write  output  1  load IR from memory read data
- ab_write  output  1  latch register-file outputs into A/B
- alu_out_write  output  1  latch ALU result
- alu_src_imm  output  1  ALU operand 2: 0=B, 1=sign-extended immediate
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request (data from B)
- mem_addr_sel  output  1  memory address: 0=PC, 1=ALU-out latch
- mdr_write  output  1  latch memory read data
- reg_write  output  1  register-file write enable
- reg_dst_rd  output  1  write register: 1=rd, 0=rt
- mem_to_reg  output  1  writeback data: 1=MDR, 0=ALU-out
- halted  output  1  illegal instruction trapped
- state  output  3  current state encoding
- retired  output  RETIRE_W  retired-instruction count, wraps

## Operation
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7. Code 6 is unused and recovers to IDLE.
- Strobe derivation: all strobes are decoded combinationally from the state register plus `opcode`/`funct`/`mem_ready`. The only registers are the state, `halted` and `retired`.
- IDLE: all strobes 0. Unconditionally goes to FETCH.
- FETCH: `mem_read`=1, `mem_addr_sel`=0.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Goes to DECODE when `mem_ready`=1; otherwise stays in FETCH.
- DECODE: `ab_write`=1.
  - Illegal encodings: opcode 100 or 101, or opcode 000 with funct 1000–1111.
  - Illegal encoding: go to HALT. Otherwise: go to EXEC.
- EXEC: `alu_out_write`=1.
  - `alu_src_imm`=1 for opcodes 001, 010, 011, 110, 111; 0 for opcode 000.
  - lw (110) and sw (111) go to MEM. All others go to WB.
- MEM: `mem_addr_sel`=1.
  - `mem_read`=1 for lw; `mem_write`=1 for sw.
  - lw: `mdr_write` = `mem_ready`.
  - On `mem_ready`=1: lw goes to WB, sw goes to FETCH. Otherwise stay in MEM.
- WB: `reg_write`=1.
  - `reg_dst_rd` = (opcode==000).
  - `mem_to_reg` = (opcode==110).
  - Goes to FETCH.
- HALT: all strobes 0, `halted`=1. Only reset leaves HALT.
- Retirement: `retired` increments by 1 on the edge leaving WB, or leaving MEM for sw. It wraps from 2^RETIRE_W−1 to 0.
- `mem_ready` is ignored outside FETCH and MEM.

## Timing
- Reset values while `rst_n`=0:
  - state=IDLE; all strobes 0.
  - `halted`=0, `retired`=0.
- Reset mid-operation: takes effect immediately (asynchronously), including in HALT or during a memory wait. No partial writeback completes after assertion.
- First FETCH: the first rising edge after `rst_n` deasserts moves IDLE→FETCH.
- Latency with `mem_ready` tied high:
  - R-type and I-type ALU instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
- Wait states: each cycle with `mem_ready`=0 in FETCH or MEM adds one cycle. Requests and address select stay constant throughout the wait.
- Handshake: an access completes on the rising edge where `mem_read`/`mem_write` and `mem_ready` are both 1. `ir_write`/`pc_write`/`mdr_write` are high in that same cycle only.
- Mutual exclusion: `mem_read` and `mem_write` are never both 1. `reg_write` is never 1 outside WB.
- Illegal trap: `halted` rises on the edge leaving DECODE. No WB or memory access occurs for that instruction, and `retired` does not increment.

## Test plan
- Reset and first fetch: hold `rst_n`=0 for 3 cycles with `mem_ready`=1, then release.
  - Required: all outputs 0 during reset.
  - Then state sequence 0,1,2,… with `ir_write`=`pc_write`=1 in the first FETCH cycle.
- add sequence: opcode=000, funct=0001, `mem_ready`=1.
  - Required: state 1→2→3→5→1.
  - In WB: `reg_write`=1, `reg_dst_rd`=1, `mem_to_reg`=0; `retired` goes 0→1.
- lw with 2 wait cycles: opcode=110, `mem_ready`=0 for 2 MEM cycles then 1.
  - Required: MEM lasts 3 cycles with `mem_read`=1 and `mem_addr_sel`=1 throughout.
  - `mdr_write` high only in the last MEM cycle.
  - WB has `mem_to_reg`=1, `reg_dst_rd`=0. Total 7 cycles.
- sw: opcode=111.
  - Required: MEM has `mem_write`=1, `mem_read`=0.
  - Next state is FETCH; `reg_write` is never 1; `retired` increments on the MEM exit edge.
- Illegal and mid-operation reset:
  - opcode=101. Required: DECODE→HALT, `halted`=1, stays in HALT for 10 cycles with all strobes 0, `retired` unchanged.
  - Then pulse `rst_n` low mid-cycle. Required: immediate IDLE and `halted`=0.
- Counter wrap: RETIRE_W=4, 16 addi (opcode 001) instructions.
  - Required: `retired` counts to 15, then wraps to 0.
  - `alu_src_imm`=1 in each EXEC.

Source files
------------

// File: rtl/mips16_mc_control_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS16 sequencer.
// master = control sequencer side, slave = datapath/memory side.
interface mips16_mc_control_if #(
    parameter int RETIRE_W = 16
);
    logic [2:0]          opcode;
    logic [3:0]          funct;
    logic                mem_ready;
    logic                pc_write;
    logic                ir_write;
    logic                ab_write;
    logic                alu_out_write;
    logic                alu_src_imm;
    logic                mem_read;
    logic                mem_write;
    logic                mem_addr_sel;
    logic                mdr_write;
    logic                reg_write;
    logic                reg_dst_rd;
    logic                mem_to_reg;
    logic                halted;
    logic [2:0]          state;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, ir_write, ab_write, alu_out_write, alu_src_imm,
               mem_read, mem_write, mem_addr_sel, mdr_write,
               reg_write, reg_dst_rd, mem_to_reg, halted, state, retired
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, ir_write, ab_write, alu_out_write, alu_src_imm,
               mem_read, mem_write, mem_addr_sel, mdr_write,
               reg_write, reg_dst_rd, mem_to_reg, halted, state, retired
    );
endinterface

// File: rtl/mips16_mc_control.sv
// Multi-cycle MIPS16 control FSM: strobes are combinational from state/opcode/mem_ready.
// 4 cycles per ALU op or sw, 5 per lw; each mem_ready=0 cycle in FETCH/MEM stalls one cycle.
module mips16_mc_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips16_mc_control_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic                halted_q, halted_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                retire_en;

    logic is_rtype, is_lw, is_sw, illegal;

    assign is_rtype = (bus.opcode == 3'b000);
    assign is_lw    = (bus.opcode == 3'b110);
    assign is_sw    = (bus.opcode == 3'b111);
    assign illegal  = (bus.opcode == 3'b100) || (bus.opcode == 3'b101) ||
                      (is_rtype && (bus.funct >= 4'b1000));

    always_comb begin
        state_d           = state_q;
        halted_d          = halted_q;
        retire_en         = 1'b0;
        bus.pc_write      = 1'b0;
        bus.ir_write      = 1'b0;
        bus.ab_write      = 1'b0;
        bus.alu_out_write = 1'b0;
        bus.alu_src_imm   = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_addr_sel  = 1'b0;
        bus.mdr_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst_rd    = 1'b0;
        bus.mem_to_reg    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_read = 1'b1;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ab_write = 1'b1;
                if (illegal) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.alu_out_write = 1'b1;
                bus.alu_src_imm   = !is_rtype;
                state_d           = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // Request and address stay asserted for the whole wait.
                bus.mem_addr_sel = 1'b1;
                bus.mem_read     = is_lw;
                bus.mem_write    = is_sw;
                bus.mdr_write    = is_lw && bus.mem_ready;
                if (bus.mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        state_d   = S_FETCH;
                        retire_en = is_sw;
                    end
                end
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst_rd = is_rtype;
                bus.mem_to_reg = is_lw;
                state_d        = S_FETCH;
                retire_en      = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        retired_d = retire_en ? (retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1}) : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.halted  = halted_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_mips16_mc_control.sv
// Directed bench for mips16_mc_control: per-cycle vector table plus hand sequences
// for halt, mid-operation reset and retired-counter wrap.
module tb_mips16_mc_control;
    localparam int RW = 4;

    logic clk;
    logic rst_n;

    mips16_mc_control_if #(.RETIRE_W(RW)) bus ();

    mips16_mc_control #(.RETIRE_W(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe order: pc ir ab alo imm mrd mwr asel mdr rw rd m2r
    typedef struct {
        logic [2:0]    op;
        logic [3:0]    fn;
        logic          mr;
        logic [2:0]    st;
        logic [11:0]   stb;
        logic          hlt;
        logic [RW-1:0] ret;
    } vec_t;

    localparam logic [11:0] S_NONE  = 12'h000;
    localparam logic [11:0] S_FET   = 12'hC40;
    localparam logic [11:0] S_FWAIT = 12'h040;
    localparam logic [11:0] S_DEC   = 12'h200;
    localparam logic [11:0] S_EXR   = 12'h100;
    localparam logic [11:0] S_EXI   = 12'h180;
    localparam logic [11:0] S_LWW   = 12'h050;
    localparam logic [11:0] S_LWD   = 12'h058;
    localparam logic [11:0] S_SW    = 12'h030;
    localparam logic [11:0] S_WBR   = 12'h006;
    localparam logic [11:0] S_WBI   = 12'h004;
    localparam logic [11:0] S_WBL   = 12'h005;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] op, logic [3:0] fn, logic mr, logic [2:0] st,
                                logic [11:0] stb, logic hlt, logic [RW-1:0] ret);
        vec_t v;
        v.op = op; v.fn = fn; v.mr = mr; v.st = st; v.stb = stb; v.hlt = hlt; v.ret = ret;
        return v;
    endfunction

    function automatic logic [11:0] strobes();
        return {bus.pc_write, bus.ir_write, bus.ab_write, bus.alu_out_write, bus.alu_src_imm,
                bus.mem_read, bus.mem_write, bus.mem_addr_sel, bus.mdr_write,
                bus.reg_write, bus.reg_dst_rd, bus.mem_to_reg};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input vec_t v, input string tag, input int idx);
        chk({tag, ".state"},   idx, 32'(bus.state),   32'(v.st));
        chk({tag, ".strobes"}, idx, 32'(strobes()),   32'(v.stb));
        chk({tag, ".halted"},  idx, 32'(bus.halted),  32'(v.hlt));
        chk({tag, ".retired"}, idx, 32'(bus.retired), 32'(v.ret));
    endtask

    // Called at a falling edge: drive, settle, check, advance to next falling edge.
    task automatic do_vec(input vec_t v, input string tag, input int idx);
        bus.opcode    = v.op;
        bus.funct     = v.fn;
        bus.mem_ready = v.mr;
        #1;
        check_outs(v, tag, idx);
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 3'b000;
        bus.funct     = 4'b0000;
        bus.mem_ready = 1'b1;

        // Reset held 3 cycles: everything zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_outs(mk(3'b000, 4'b0000, 1'b1, 3'd0, S_NONE, 1'b0, '0), "reset", i);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // add; lw with 2 MEM waits; sw with 1 FETCH wait; illegal opcode 101.
        tbl.push_back(mk(3'b000, 4'b0001, 1'b1, 3'd0, S_NONE,  1'b0, 4'd0));
        tbl.push_back(mk(3'b000, 4'b0001, 1'b1, 3'd1, S_FET,   1'b0, 4'd0));
        tbl.push_back(mk(3'b000, 4'b0001, 1'b0, 3'd2, S_DEC,   1'b0, 4'd0));
        tbl.push_back(mk(3'b000, 4'b0001, 1'b0, 3'd3, S_EXR,   1'b0, 4'd0));
        tbl.push_back(mk(3'b000, 4'b0001, 1'b0, 3'd5, S_WBR,   1'b0, 4'd0));
        tbl.push_back(mk(3'b110, 4'b0000, 1'b1, 3'd1, S_FET,   1'b0, 4'd1));
        tbl.push_back(mk(3'b110, 4'b0000, 1'b1, 3'd2, S_DEC,   1'b0, 4'd1));
        tbl.push_back(mk(3'b110, 4'b0000, 1'b1, 3'd3, S_EXI,   1'b0, 4'd1));
        tbl.push_back(mk(3'b110, 4'b0000, 1'b0, 3'd4, S_LWW,   1'b0, 4'd1));
        tbl.push_back(mk(3'b110, 4'b0000, 1'b0, 3'd4, S_LWW,   1'b0, 4'd1));
        tbl.push_back(mk(3'b110, 4'b0000, 1'b1, 3'd4, S_LWD,   1'b0, 4'd1));
        tbl.push_back(mk(3'b110, 4'b0000, 1'b1, 3'd5, S_WBL,   1'b0, 4'd1));
        tbl.push_back(mk(3'b111, 4'b0000, 1'b0, 3'd1, S_FWAIT, 1'b0, 4'd2));
        tbl.push_back(mk(3'b111, 4'b0000, 1'b1, 3'd1, S_FET,   1'b0, 4'd2));
        tbl.push_back(mk(3'b111, 4'b0000, 1'b0, 3'd2, S_DEC,   1'b0, 4'd2));
        tbl.push_back(mk(3'b111, 4'b0000, 1'b1, 3'd3, S_EXI,   1'b0, 4'd2));
        tbl.push_back(mk(3'b111, 4'b0000, 1'b1, 3'd4, S_SW,    1'b0, 4'd2));
        tbl.push_back(mk(3'b101, 4'b0000, 1'b1, 3'd1, S_FET,   1'b0, 4'd3));
        tbl.push_back(mk(3'b101, 4'b0000, 1'b1, 3'd2, S_DEC,   1'b0, 4'd3));
        tbl.push_back(mk(3'b101, 4'b0000, 1'b1, 3'd7, S_NONE,  1'b1, 4'd3));

        foreach (tbl[i]) do_vec(tbl[i], "tbl", i);

        // HALT is sticky regardless of mem_ready.
        for (int i = 0; i < 10; i++)
            do_vec(mk(3'b101, 4'b0000, logic'(i % 2), 3'd7, S_NONE, 1'b1, 4'd3), "halt", i);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check_outs(mk(3'b101, 4'b0000, 1'b0, 3'd0, S_NONE, 1'b0, 4'd0), "arst", 0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type with funct 1xxx traps too.
        do_vec(mk(3'b000, 4'b1001, 1'b1, 3'd0, S_NONE, 1'b0, 4'd0), "illr", 0);
        do_vec(mk(3'b000, 4'b1001, 1'b1, 3'd1, S_FET,  1'b0, 4'd0), "illr", 1);
        do_vec(mk(3'b000, 4'b1001, 1'b1, 3'd2, S_DEC,  1'b0, 4'd0), "illr", 2);
        do_vec(mk(3'b000, 4'b1001, 1'b1, 3'd7, S_NONE, 1'b1, 4'd0), "illr", 3);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_vec(mk(3'b001, 4'b0000, 1'b1, 3'd0, S_NONE, 1'b0, 4'd0), "wrap_idle", 0);

        // 16 addi instructions: retired climbs to 15 then wraps to 0.
        for (int k = 0; k < 16; k++) begin
            do_vec(mk(3'b001, 4'b0000, 1'b1, 3'd1, S_FET, 1'b0, RW'(k)), "wrap_f", k);
            do_vec(mk(3'b001, 4'b0000, 1'b0, 3'd2, S_DEC, 1'b0, RW'(k)), "wrap_d", k);
            do_vec(mk(3'b001, 4'b0000, 1'b1, 3'd3, S_EXI, 1'b0, RW'(k)), "wrap_e", k);
            do_vec(mk(3'b001, 4'b0000, 1'b0, 3'd5, S_WBI, 1'b0, RW'(k)), "wrap_w", k);
        end
        do_vec(mk(3'b001, 4'b0000, 1'b0, 3'd1, S_FWAIT, 1'b0, 4'd0), "wrap_end", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
